// File: rtl/mvu_pkg.sv
// Shared types for the MVU job scheduler: default sizes, job descriptor and
// dispatch FSM state encoding.
package mvu_pkg;

    localparam int NMVU_DEF = 8;
    localparam int BTAG_DEF = 8;
    localparam int BMVUID   = $clog2(NMVU_DEF);

    // `wait` is a keyword, so the barrier flag is called wait_all.
    typedef struct packed {
        logic [BMVUID-1:0]   mvu;
        logic                wait_all;
        logic [BTAG_DEF-1:0] tag;
    } mvu_job_t;

    typedef enum logic [1:0] {
        SCHED_IDLE  = 2'd0,
        SCHED_CLR   = 2'd1,
        SCHED_START = 2'd2
    } sched_state_t;

endpackage

// File: rtl/mvu_job_fifo.sv
// Synchronous FIFO holding pending job descriptors. Flags are registered;
// empty_next exposes the emptiness that will be visible after this edge.
module mvu_job_fifo #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic             empty_next
);

    localparam int BPTR = $clog2(DEPTH);
    localparam logic [BPTR:0] FULL_CNT = (BPTR+1)'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [BPTR-1:0]  wr_ptr_r;
    logic [BPTR-1:0]  rd_ptr_r;
    logic [BPTR:0]    count_r;
    logic [BPTR:0]    count_s;
    logic             full_r;
    logic             empty_r;
    logic             do_push_s;
    logic             do_pop_s;

    // Accept/retire decisions and next occupancy.
    always_comb begin
        do_pop_s  = pop && !empty_r;
        do_push_s = push && (!full_r || do_pop_s);
        case ({do_push_s, do_pop_s})
            2'b10:   count_s = count_r + (BPTR+1)'(1);
            2'b01:   count_s = count_r - (BPTR+1)'(1);
            default: count_s = count_r;
        endcase
    end

    // Storage, pointers and registered flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= din;
                wr_ptr_r        <= wr_ptr_r + BPTR'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + BPTR'(1);
            end
            count_r <= count_s;
            full_r  <= (count_s == FULL_CNT);
            empty_r <= (count_s == '0);
        end
    end

    assign dout       = mem_r[rd_ptr_r];
    assign full       = full_r;
    assign empty      = empty_r;
    assign empty_next = (count_s == '0);

endmodule

// File: rtl/mvu_job_sched.sv
// MVU job scheduler: queues host jobs, dispatches clear+start pulses in order,
// tracks per-MVU busy/pending state and reports completions lowest index first.
module mvu_job_sched
    import mvu_pkg::*;
#(
    parameter int NMVU   = NMVU_DEF,
    parameter int QDEPTH = 4,
    parameter int BTAG   = BTAG_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    job_valid,
    output logic                    job_ready,
    input  logic [$clog2(NMVU)-1:0] job_mvu,
    input  logic [BTAG-1:0]         job_tag,
    input  logic                    job_wait,
    output logic [NMVU-1:0]         clr,
    output logic [NMVU-1:0]         start,
    input  logic [NMVU-1:0]         done,
    output logic [NMVU-1:0]         busy,
    output logic                    cpl_valid,
    output logic [$clog2(NMVU)-1:0] cpl_mvu,
    output logic [BTAG-1:0]         cpl_tag,
    output logic                    idle,
    output logic                    err_spurious
);

    localparam int BMVU = $clog2(NMVU);

    typedef struct packed {
        logic [BMVU-1:0] mvu;
        logic            wait_all;
        logic [BTAG-1:0] tag;
    } job_t;

    localparam int BJOB = $bits(job_t);

    function automatic logic [NMVU-1:0] onehot(input logic [BMVU-1:0] idx);
        logic [NMVU-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    job_t             job_in_s;
    job_t             head_s;
    logic [BJOB-1:0]  head_bits_s;
    logic             fifo_full_s;
    logic             fifo_empty_s;
    logic             fifo_empty_next_s;
    logic             push_s;
    logic             pop_s;
    logic             eligible_s;

    sched_state_t     state_r;
    sched_state_t     state_n;
    logic [BMVU-1:0]  cur_mvu_r;
    logic [BTAG-1:0]  cur_tag_r;
    logic [BTAG-1:0]  tag_r [NMVU];

    logic [NMVU-1:0]  clr_r;
    logic [NMVU-1:0]  start_r;
    logic [NMVU-1:0]  busy_r;
    logic [NMVU-1:0]  pend_r;
    logic [NMVU-1:0]  rel_r;
    logic             cpl_valid_r;
    logic [BMVU-1:0]  cpl_mvu_r;
    logic [BTAG-1:0]  cpl_tag_r;
    logic             idle_r;
    logic             err_r;

    logic [NMVU-1:0]  clr_n;
    logic [NMVU-1:0]  start_n;
    logic [NMVU-1:0]  set_s;
    logic [NMVU-1:0]  done_ok_s;
    logic [NMVU-1:0]  pend_eff_s;
    logic [NMVU-1:0]  sel_mask_s;
    logic [NMVU-1:0]  pend_n;
    logic [NMVU-1:0]  busy_n;
    logic [BMVU-1:0]  sel_idx_s;
    logic             sel_valid_s;
    logic             spur_s;
    logic             idle_n;

    assign job_in_s = '{mvu: job_mvu, wait_all: job_wait, tag: job_tag};
    assign head_s   = job_t'(head_bits_s);
    assign push_s   = job_valid && !fifo_full_s;

    mvu_job_fifo #(
        .WIDTH (BJOB),
        .DEPTH (QDEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push_s),
        .din        (job_in_s),
        .pop        (pop_s),
        .dout       (head_bits_s),
        .full       (fifo_full_s),
        .empty      (fifo_empty_s),
        .empty_next (fifo_empty_next_s)
    );

    // Dispatch FSM: eligibility of the queue head and next-cycle pulses.
    always_comb begin
        state_n    = state_r;
        pop_s      = 1'b0;
        clr_n      = '0;
        start_n    = '0;
        set_s      = '0;
        eligible_s = 1'b0;
        if (!fifo_empty_s && !busy_r[head_s.mvu]) begin
            eligible_s = !head_s.wait_all || (!(|busy_r) && !(|pend_r));
        end else begin
            eligible_s = 1'b0;
        end
        case (state_r)
            SCHED_IDLE: begin
                if (eligible_s) begin
                    pop_s   = 1'b1;
                    clr_n   = onehot(head_s.mvu);
                    state_n = SCHED_CLR;
                end else begin
                    state_n = SCHED_IDLE;
                end
            end
            SCHED_CLR: begin
                start_n = onehot(cur_mvu_r);
                set_s   = onehot(cur_mvu_r);
                state_n = SCHED_START;
            end
            SCHED_START: state_n = SCHED_IDLE;
            default:     state_n = SCHED_IDLE;
        endcase
    end

    // Completion intake and lowest-index report selection. A done during the
    // report cycle of the same MVU is treated as spurious, like any other
    // done without an outstanding job; busy drops one cycle after the report.
    always_comb begin
        done_ok_s   = done & busy_r & ~pend_r & ~rel_r;
        spur_s      = |(done & ~done_ok_s);
        pend_eff_s  = pend_r | done_ok_s;
        sel_valid_s = |pend_eff_s;
        sel_idx_s   = '0;
        for (int i = NMVU - 1; i >= 0; i--) begin
            sel_idx_s = pend_eff_s[i] ? BMVU'(i) : sel_idx_s;
        end
        sel_mask_s = sel_valid_s ? onehot(sel_idx_s) : '0;
        pend_n     = pend_eff_s & ~sel_mask_s;
        busy_n     = (busy_r & ~rel_r) | set_s;
        idle_n     = fifo_empty_next_s && (state_n == SCHED_IDLE) &&
                     !(|busy_n) && !(|pend_n);
    end

    // State, tracking and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= SCHED_IDLE;
            cur_mvu_r   <= '0;
            cur_tag_r   <= '0;
            for (int i = 0; i < NMVU; i++) begin
                tag_r[i] <= '0;
            end
            clr_r       <= '0;
            start_r     <= '0;
            busy_r      <= '0;
            pend_r      <= '0;
            rel_r       <= '0;
            cpl_valid_r <= 1'b0;
            cpl_mvu_r   <= '0;
            cpl_tag_r   <= '0;
            idle_r      <= 1'b1;
            err_r       <= 1'b0;
        end else begin
            state_r <= state_n;
            if (pop_s) begin
                cur_mvu_r <= head_s.mvu;
                cur_tag_r <= head_s.tag;
            end
            if (state_r == SCHED_CLR) begin
                tag_r[cur_mvu_r] <= cur_tag_r;
            end
            clr_r       <= clr_n;
            start_r     <= start_n;
            busy_r      <= busy_n;
            pend_r      <= pend_n;
            rel_r       <= sel_mask_s;
            cpl_valid_r <= sel_valid_s;
            if (sel_valid_s) begin
                cpl_mvu_r <= sel_idx_s;
                cpl_tag_r <= tag_r[sel_idx_s];
            end
            idle_r <= idle_n;
            err_r  <= err_r | spur_s;
        end
    end

    assign job_ready    = !fifo_full_s;
    assign clr          = clr_r;
    assign start        = start_r;
    assign busy         = busy_r;
    assign cpl_valid    = cpl_valid_r;
    assign cpl_mvu      = cpl_mvu_r;
    assign cpl_tag      = cpl_tag_r;
    assign idle         = idle_r;
    assign err_spurious = err_r;

endmodule

// File: tb/tb_mvu_job_sched.sv
// Bench for mvu_job_sched: directed scenarios plus random traffic, all checked
// against a queue-based model of the scheduling rules.
module tb_mvu_job_sched;
    import mvu_pkg::*;

    logic       clk;
    logic       rst;
    logic       job_valid;
    logic       job_ready;
    logic [2:0] job_mvu;
    logic [7:0] job_tag;
    logic       job_wait;
    logic [7:0] clr;
    logic [7:0] start;
    logic [7:0] done;
    logic [7:0] busy;
    logic       cpl_valid;
    logic [2:0] cpl_mvu;
    logic [7:0] cpl_tag;
    logic       idle;
    logic       err_spurious;

    int n_checks = 0;
    int n_errors = 0;

    mvu_job_sched #(.NMVU(8), .QDEPTH(4), .BTAG(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .job_valid    (job_valid),
        .job_ready    (job_ready),
        .job_mvu      (job_mvu),
        .job_tag      (job_tag),
        .job_wait     (job_wait),
        .clr          (clr),
        .start        (start),
        .done         (done),
        .busy         (busy),
        .cpl_valid    (cpl_valid),
        .cpl_mvu      (cpl_mvu),
        .cpl_tag      (cpl_tag),
        .idle         (idle),
        .err_spurious (err_spurious)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: job queue, dispatch phase, busy/pending sets.
    mvu_job_t   mq[$];
    mvu_job_t   cur;
    int         phase;
    bit [7:0]   mb;
    bit [7:0]   mp;
    int         rel;
    logic [7:0] mtags [8];
    logic [7:0] e_clr;
    logic [7:0] e_start;
    logic       e_cv;
    logic [2:0] e_cm;
    logic [7:0] e_ct;
    logic       e_ready;
    logic       e_idle;
    logic       e_err;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input bit acc);
        bit disp;
        int sel;
        if (rst) begin
            mq.delete();
            phase = 0; mb = '0; mp = '0; rel = -1;
            e_clr = '0; e_start = '0; e_cv = 1'b0; e_cm = '0; e_ct = '0;
            e_ready = 1'b1; e_idle = 1'b1; e_err = 1'b0;
            return;
        end
        disp = 1'b0;
        if (phase == 0 && mq.size() > 0)
            disp = !mb[mq[0].mvu] && (!mq[0].wait_all || (mb == 0 && mp == 0));
        for (int i = 0; i < 8; i++) begin
            if (done[i]) begin
                if (mb[i] && !mp[i] && rel != i) mp[i] = 1'b1;
                else e_err = 1'b1;
            end
        end
        sel = -1;
        for (int i = 7; i >= 0; i--) if (mp[i]) sel = i;
        e_cv = (sel >= 0);
        if (sel >= 0) begin
            e_cm = 3'(sel); e_ct = mtags[sel]; mp[sel] = 1'b0;
        end
        if (rel >= 0) mb[rel] = 1'b0;
        if (phase == 1) begin
            mb[cur.mvu] = 1'b1; mtags[cur.mvu] = cur.tag;
        end
        rel = sel;
        e_clr = '0; e_start = '0;
        case (phase)
            1: begin e_start[cur.mvu] = 1'b1; phase = 2; end
            2: phase = 0;
            default: if (disp) begin
                cur = mq.pop_front(); e_clr[cur.mvu] = 1'b1; phase = 1;
            end
        endcase
        if (acc) mq.push_back('{mvu: job_mvu, wait_all: job_wait, tag: job_tag});
        e_ready = (mq.size() < 4);
        e_idle  = (mq.size() == 0) && (phase == 0) && (mb == 0) && (mp == 0);
    endtask

    task automatic compare_all();
        check_eq("job_ready", job_ready, e_ready);
        check_eq("clr", clr, e_clr);
        check_eq("start", start, e_start);
        check_eq("busy", busy, mb);
        check_eq("cpl_valid", cpl_valid, e_cv);
        if (e_cv) begin
            check_eq("cpl_mvu", cpl_mvu, e_cm);
            check_eq("cpl_tag", cpl_tag, e_ct);
        end
        check_eq("idle", idle, e_idle);
        check_eq("err_spurious", err_spurious, e_err);
    endtask

    // One clock: inputs are sampled at the edge, outputs checked 1 time unit later.
    task automatic tick();
        bit acc;
        acc = job_valid && e_ready;
        @(posedge clk);
        #1;
        model_step(acc);
        compare_all();
        if (acc) job_valid = 1'b0;
    endtask

    task automatic push_job(input int m, input bit w, input logic [7:0] t);
        int n;
        n = 0;
        job_mvu = 3'(m); job_wait = w; job_tag = t; job_valid = 1'b1;
        while (job_valid && n < 16) begin tick(); n++; end
        check_eq("push_accepted", job_valid, 1'b0);
        job_valid = 1'b0;
    endtask

    task automatic wait_start(input int m, input int budget);
        int n;
        n = 0;
        while (start[m] !== 1'b1 && n < budget) begin tick(); n++; end
        check_eq($sformatf("start_%0d_seen", m), start[m], 1'b1);
    endtask

    task automatic pulse_done(input logic [7:0] m);
        done = m;
        tick();
        done = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit saw;
        rst = 1'b1; job_valid = 1'b0; job_mvu = '0; job_tag = '0; job_wait = 1'b0; done = '0;
        for (int i = 0; i < 8; i++) mtags[i] = '0;
        tick(); tick();
        check_eq("rst_ready", job_ready, 1'b1);
        check_eq("rst_idle", idle, 1'b1);
        check_eq("rst_cpl_mvu", cpl_mvu, 3'd0);
        check_eq("rst_cpl_tag", cpl_tag, 8'h00);
        rst = 1'b0;
        tick();

        // Single job latency and completion.
        push_job(2, 1'b0, 8'h11);
        tick();
        check_eq("s1_clr", clr, 8'h04);
        tick();
        check_eq("s1_start", start, 8'h04);
        check_eq("s1_busy", busy, 8'h04);
        tick(); tick();
        pulse_done(8'h04);
        check_eq("s1_cpl_valid", cpl_valid, 1'b1);
        check_eq("s1_cpl_mvu", cpl_mvu, 3'd2);
        check_eq("s1_cpl_tag", cpl_tag, 8'h11);
        tick();
        check_eq("s1_idle", idle, 1'b1);

        // Queue fill on a busy MVU, then in-order draining.
        push_job(0, 1'b0, 8'hA0);
        wait_start(0, 8);
        for (int k = 0; k < 4; k++) push_job(0, 1'b0, 8'(8'hB0 + k));
        check_eq("s2_full_ready", job_ready, 1'b0);
        job_mvu = 3'd0; job_wait = 1'b0; job_tag = 8'hB4; job_valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            pulse_done(8'h01);
            check_eq("s2_cpl_valid", cpl_valid, 1'b1);
            check_eq("s2_cpl_tag", cpl_tag, (k == 0) ? 8'hA0 : 8'(8'hB0 + k - 1));
            if (k < 5) wait_start(0, 12);
        end
        check_eq("s2_last_taken", job_valid, 1'b0);
        job_valid = 1'b0;
        tick(); tick();

        // Head-of-line blocking.
        push_job(1, 1'b0, 8'h21);
        wait_start(1, 8);
        push_job(1, 1'b0, 8'h22);
        push_job(3, 1'b0, 8'h23);
        saw = 1'b0;
        repeat (8) begin tick(); if (start[3]) saw = 1'b1; end
        check_eq("s3_no_start3", saw, 1'b0);
        pulse_done(8'h02);
        check_eq("s3_cpl_tag", cpl_tag, 8'h21);
        wait_start(1, 8);
        wait_start(3, 8);
        check_eq("s3_busy", busy, 8'h0A);

        // Simultaneous completions reported in ascending order.
        push_job(0, 1'b0, 8'h20);
        wait_start(0, 8);
        tick();
        check_eq("s4_busy", busy, 8'h0B);
        pulse_done(8'h0B);
        check_eq("s4_cpl0", {cpl_valid, cpl_mvu, cpl_tag}, {1'b1, 3'd0, 8'h20});
        tick();
        check_eq("s4_cpl1", {cpl_valid, cpl_mvu, cpl_tag}, {1'b1, 3'd1, 8'h22});
        tick();
        check_eq("s4_cpl3", {cpl_valid, cpl_mvu, cpl_tag}, {1'b1, 3'd3, 8'h23});
        tick();
        check_eq("s4_done_reporting", cpl_valid, 1'b0);
        tick();
        check_eq("s4_busy_clear", busy, 8'h00);

        // Barrier job waits for the whole array.
        push_job(0, 1'b0, 8'h30);
        wait_start(0, 8);
        push_job(2, 1'b0, 8'h32);
        wait_start(2, 8);
        push_job(5, 1'b1, 8'h35);
        saw = 1'b0;
        repeat (6) begin tick(); if (clr[5]) saw = 1'b1; end
        pulse_done(8'h01);
        if (clr[5]) saw = 1'b1;
        repeat (3) begin tick(); if (clr[5]) saw = 1'b1; end
        pulse_done(8'h04);
        if (clr[5]) saw = 1'b1;
        tick();
        if (clr[5]) saw = 1'b1;
        check_eq("s5_busy_zero", busy, 8'h00);
        check_eq("s5_no_early_clr5", saw, 1'b0);
        tick();
        check_eq("s5_clr5", clr, 8'h20);
        wait_start(5, 4);
        pulse_done(8'h20);
        tick(); tick();

        // Spurious completion and reset in the middle of a dispatch.
        check_eq("s6_err_clean", err_spurious, 1'b0);
        pulse_done(8'h40);
        check_eq("s6_err_set", err_spurious, 1'b1);
        repeat (3) tick();
        check_eq("s6_err_held", err_spurious, 1'b1);
        push_job(4, 1'b0, 8'h44);
        tick();
        check_eq("s6_clr4", clr, 8'h10);
        rst = 1'b1;
        tick();
        check_eq("s6_rst_start", start, 8'h00);
        check_eq("s6_rst_ready", job_ready, 1'b1);
        check_eq("s6_rst_idle", idle, 1'b1);
        check_eq("s6_rst_err", err_spurious, 1'b0);
        rst = 1'b0;
        repeat (4) tick();

        // Random traffic.
        for (int c = 0; c < 1500; c++) begin
            if (!job_valid && $urandom_range(0, 2) == 0) begin
                job_mvu   = 3'($urandom_range(0, 7));
                job_tag   = 8'($urandom);
                job_wait  = ($urandom_range(0, 7) == 0);
                job_valid = 1'b1;
            end
            done = '0;
            for (int i = 0; i < 8; i++) if (mb[i] && $urandom_range(0, 5) == 0) done[i] = 1'b1;
            if ($urandom_range(0, 63) == 0) done[$urandom_range(0, 7)] = 1'b1;
            rst = ($urandom_range(0, 499) == 0);
            tick();
        end
        done = '0; rst = 1'b0; job_valid = 1'b0;
        repeat (4) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
